instr_packer: RTL and testbench

- Reverse of the instruction field splitter: takes decoded MIPS fields plus a format code and packs them into a 32-bit instruction word.
- Each packed word is queued in a small FIFO and tagged with its instruction-memory byte address.
- Feeds the IM preload/loader path, with a valid/ready handshake on both sides.

---
 rtl/instr_packer_pkg.sv | 24 ++
 rtl/instr_packer_if.sv | 22 ++
 rtl/instr_packer_sync_fifo.sv | 46 ++++
 rtl/instr_packer.sv | 58 +++++
 tb/tb_instr_packer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/instr_packer_pkg.sv
// instr_pkg: MIPS format codes, field widths and the shared field-packing function.
package instr_pkg;
    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_J = 2'b10;
    localparam logic [1:0] FMT_RSV = 2'b11;
    localparam int OP_W = 6;
    localparam int REG_W = 5;
    localparam int IMM16_W = 16;
    localparam int IMM26_W = 26;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_3000;

    function automatic logic [31:0] pack(
        input logic [1:0] fmt,
        input logic [OP_W-1:0] op, func,
        input logic [REG_W-1:0] rs, rt, rd, shamt,
        input logic [IMM16_W-1:0] imm16,
        input logic [IMM26_W-1:0] imm26
    );
        return fmt == FMT_R ? {op, rs, rt, rd, shamt, func} :
               fmt == FMT_I ? {op, rs, rt, imm16} :
               fmt == FMT_J ? {op, imm26} : 32'h0;
    endfunction
endpackage

// File: rtl/instr_packer_if.sv
// instr_packer_if: field-tuple input and packed-word output handshakes of the packer.
interface instr_packer_if #(parameter int CW = 3) ();
    logic in_valid, in_ready;
    logic [1:0] fmt;
    logic [instr_pkg::OP_W-1:0] op, func;
    logic [instr_pkg::REG_W-1:0] rs, rt, rd, shamt;
    logic [instr_pkg::IMM16_W-1:0] imm16;
    logic [instr_pkg::IMM26_W-1:0] imm26;
    logic out_valid, out_ready;
    logic [31:0] out_instr, out_addr;
    logic [CW-1:0] count;
    logic err;

    modport master (
        output in_valid, fmt, op, func, rs, rt, rd, shamt, imm16, imm26, out_ready,
        input in_ready, out_valid, out_instr, out_addr, count, err
    );
    modport slave (
        input in_valid, fmt, op, func, rs, rt, rd, shamt, imm16, imm26, out_ready,
        output in_ready, out_valid, out_instr, out_addr, count, err
    );
endinterface

// File: rtl/instr_packer_sync_fifo.sv
// sync_fifo: DEPTH x W synchronous FIFO; when empty the read port shows the last popped entry.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 64,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push_i,
    input  logic pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic [CW-1:0] count_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic do_push, do_pop;

    assign full_o = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop = pop_i && !empty_o;
    assign count_o = cnt_q;
    // Stepping back one slot when empty keeps the last popped word visible (zero after reset).
    assign rdata_o = mem_q[empty_o ? rd_q - AW'(1) : rd_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/instr_packer.sv
// instr_packer: packs MIPS fields into address-tagged words queued for the IM loader.
// Define INSTR_PACKER_FMT_CHECK_EN to also reject opcode/format mismatches.
module instr_packer
    import instr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input logic clk,
    input logic reset_n,
    instr_packer_if.slave bus
);
    logic [31:0] addr_q, addr_d;
    logic err_q, err_d;
    logic full, empty, accept, legal, push;
    logic [63:0] head;

    always_comb begin
`ifdef INSTR_PACKER_FMT_CHECK_EN
        legal = bus.fmt != FMT_RSV && ((bus.fmt == FMT_R) == (bus.op == '0));
`else
        legal = bus.fmt != FMT_RSV;
`endif
        accept = bus.in_valid && !full;
        push = accept && legal;
        addr_d = push ? addr_q + 32'd4 : addr_q;
        err_d = err_q || (accept && !legal);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= BASE_ADDR;
            err_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q <= err_d;
        end
    end

    sync_fifo #(.DEPTH(DEPTH), .W(64), .CW(CW)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push_i(push),
        .pop_i(bus.out_ready),
        .wdata_i({addr_q, pack(bus.fmt, bus.op, bus.func, bus.rs, bus.rt, bus.rd, bus.shamt, bus.imm16, bus.imm26)}),
        .rdata_o(head),
        .count_o(bus.count),
        .full_o(full),
        .empty_o(empty)
    );

    assign bus.in_ready = !full;
    assign bus.out_valid = !empty;
    assign bus.out_addr = head[63:32];
    assign bus.out_instr = head[31:0];
    assign bus.err = err_q;
endmodule

// File: tb/tb_instr_packer.sv
// tb_instr_packer: directed self-checking bench for instr_packer with hand-computed expectations.
module tb_instr_packer;
    logic clk, reset_n;
    int errors = 0;
    int checks = 0;

    instr_packer_if #(.CW(3)) bus ();
    instr_packer #(.DEPTH(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                         input logic [15:0] i16, input logic [25:0] i26);
        bus.fmt = f; bus.op = o; bus.rs = s; bus.rt = t; bus.rd = d;
        bus.shamt = sh; bus.func = fn; bus.imm16 = i16; bus.imm26 = i26;
        bus.in_valid = 1'b1;
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] i16, input logic [25:0] i26);
        drive(f, o, s, t, d, sh, fn, i16, i26);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // R tuple whose packed word equals fn; unused imm fields are all ones to show they are ignored.
    task automatic drive_r(input logic [5:0] fn);
        drive(2'b00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, fn, 16'hFFFF, 26'h3FF_FFFF);
    endtask

    task automatic push_r(input logic [5:0] fn);
        drive_r(fn);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.fmt = 2'b00; bus.op = '0; bus.func = '0;
        bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.shamt = '0; bus.imm16 = '0; bus.imm26 = '0;
        reset_n = 1'b0;
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_instr", bus.out_instr, 0);
        chk("rst_addr", bus.out_addr, 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        reset_n = 1'b1;

        send(2'b00, 6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h21, 16'hABCD, 26'h155_5555);
        chk("r_valid", 32'(bus.out_valid), 1);
        chk("r_instr", bus.out_instr, 32'h0109_5021);
        chk("r_addr", bus.out_addr, 32'h0000_3000);
        chk("r_count", 32'(bus.count), 1);

        do_reset();
        send(2'b01, 6'h0D, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h1234, 26'h3FF_FFFF);
        send(2'b10, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h000_0C00);
        chk("ij_count", 32'(bus.count), 2);
        chk("i_instr", bus.out_instr, 32'h3408_1234);
        chk("i_addr", bus.out_addr, 32'h0000_3000);
        pop();
        chk("j_instr", bus.out_instr, 32'h0800_0C00);
        chk("j_addr", bus.out_addr, 32'h0000_3004);
        pop();
        chk("ij_empty", 32'(bus.out_valid), 0);

        do_reset();
        for (int i = 1; i <= 4; i++) push_r(6'(i));
        chk("full_in_ready", 32'(bus.in_ready), 0);
        chk("full_count", 32'(bus.count), 4);
        drive_r(6'd5);
        tick();
        chk("held_count", 32'(bus.count), 4);
        chk("held_instr", bus.out_instr, 32'h0000_0001);
        chk("held_addr", bus.out_addr, 32'h0000_3000);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("nobypass_count", 32'(bus.count), 3);
        chk("nobypass_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        chk("fifth_count", 32'(bus.count), 4);
        for (int i = 2; i <= 5; i++) begin
            chk("drain_instr", bus.out_instr, 32'(i));
            chk("drain_addr", bus.out_addr, 32'h0000_3000 + 32'(4 * (i - 1)));
            pop();
        end
        chk("drain_count", 32'(bus.count), 0);

        do_reset();
        push_r(6'h11);
        send(2'b11, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'h1111, 26'h222_2222);
        chk("ill_err", 32'(bus.err), 1);
        chk("ill_count", 32'(bus.count), 1);
        push_r(6'h12);
        chk("ill_instr0", bus.out_instr, 32'h0000_0011);
        chk("ill_addr0", bus.out_addr, 32'h0000_3000);
        pop();
        chk("ill_instr1", bus.out_instr, 32'h0000_0012);
        chk("ill_addr1", bus.out_addr, 32'h0000_3004);
        pop();
        chk("ill_err_sticky", 32'(bus.err), 1);
        do_reset();
        chk("ill_err_cleared", 32'(bus.err), 0);

        push_r(6'h21);
        push_r(6'h22);
        drive_r(6'h23);
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("pp_count", 32'(bus.count), 2);
        chk("pp_instr0", bus.out_instr, 32'h0000_0022);
        chk("pp_addr0", bus.out_addr, 32'h0000_3004);
        pop();
        chk("pp_instr1", bus.out_instr, 32'h0000_0023);
        chk("pp_addr1", bus.out_addr, 32'h0000_3008);

        do_reset();
        for (int i = 1; i <= 3; i++) push_r(6'(i));
        send(2'b11, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0);
        chk("mid_count", 32'(bus.count), 3);
        chk("mid_err", 32'(bus.err), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.out_valid), 0);
        chk("async_count", 32'(bus.count), 0);
        chk("async_err", 32'(bus.err), 0);
        tick();
        reset_n = 1'b1;
        push_r(6'h07);
        chk("post_rst_addr", bus.out_addr, 32'h0000_3000);
        chk("post_rst_instr", bus.out_instr, 32'h0000_0007);

        do_reset();
        send(2'b00, 6'h23, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'h0, 26'h0);
`ifdef INSTR_PACKER_FMT_CHECK_EN
        chk("fc_err", 32'(bus.err), 1);
        chk("fc_count", 32'(bus.count), 0);
`else
        chk("fc_err", 32'(bus.err), 0);
        chk("fc_count", 32'(bus.count), 1);
        chk("fc_instr", bus.out_instr, 32'h8C22_1905);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
